// File: rtl/mskaes_input_sharer.sv
// ============================================================================
//  mskaes_input_sharer
//  Splits unmasked plaintext/key words into d bit-interleaved Boolean shares.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mskaes_input_sharer #(
  parameter int d = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  input  logic                  rnd_valid,
  input  logic [32*(d-1)-1:0]   rnd,
  output logic                  rnd_ready,
  output logic [128*d-1:0]      sh_plaintext,
  output logic [128*d-1:0]      sh_key,
  output logic                  valid_out,
  input  logic                  core_ready,
  input  logic                  flush
);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic             w_accept;
  logic [32*d-1:0]  w_word_sh;
  logic [128*d-1:0] r_pt;
  logic [128*d-1:0] r_key;

  // nrst gates the handshakes so nothing is consumed while reset is held
  assign in_ready     = (r_state == LOAD) && rnd_valid && !flush && nrst;
  assign w_accept     = in_valid && in_ready;
  assign rnd_ready    = w_accept;
  assign valid_out    = (r_state == OFFER);
  assign sh_plaintext = r_pt;
  assign sh_key       = r_key;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOAD: begin
        if (flush) begin
          w_cnt_nxt = 3'd0;
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_state_nxt = OFFER;
          end
        end
      end
      OFFER: begin
        if (core_ready) begin
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Share 0 absorbs the data bit; the plain word only ever exists on this wire
  always_comb begin
    w_word_sh = '0;
    for (int b = 0; b < 32; b++) begin
      w_word_sh[d*b] = in_data[b];
      for (int j = 1; j < d; j++) begin
        w_word_sh[d*b+j] = rnd[(j-1)*32+b];
        w_word_sh[d*b]   = w_word_sh[d*b] ^ rnd[(j-1)*32+b];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= LOAD;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pt  <= '0;
      r_key <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < 4; k++) begin
        if (r_cnt[1:0] == 2'(k)) begin
          if (!r_cnt[2]) begin
            r_pt[k*32*d +: 32*d] <= w_word_sh;
          end else begin
            r_key[k*32*d +: 32*d] <= w_word_sh;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mskaes_input_sharer.sv
// Directed bench for mskaes_input_sharer at d=2 and d=3 with a share-level model
// and a scoreboard of expected unmasked blocks.
`default_nettype none

module tb_mskaes_input_sharer;

  logic         clk;
  logic         nrst;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         rnd_valid;
  logic         flush;
  logic         core_ready;
  logic [31:0]  rnd2;
  logic [63:0]  rnd3;

  logic         in_ready2, rnd_ready2, valid_out2;
  logic [255:0] sh_pt2, sh_key2;
  logic         in_ready3, rnd_ready3, valid_out3;
  logic [383:0] sh_pt3, sh_key3;

  mskaes_input_sharer #(.d(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .rnd_valid(rnd_valid), .rnd(rnd2),
    .rnd_ready(rnd_ready2), .sh_plaintext(sh_pt2), .sh_key(sh_key2),
    .valid_out(valid_out2), .core_ready(core_ready), .flush(flush)
  );

  mskaes_input_sharer #(.d(3)) u_dut3 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready3), .rnd_valid(rnd_valid), .rnd(rnd3),
    .rnd_ready(rnd_ready3), .sh_plaintext(sh_pt3), .sh_key(sh_key3),
    .valid_out(valid_out3), .core_ready(core_ready), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_pulses = 0;

  // Reference model state
  logic         m_offer;
  int           m_cnt;
  logic [255:0] m_pt2, m_key2;
  logic [383:0] m_pt3, m_key3;
  logic [127:0] m_pt_u, m_key_u;
  logic [255:0] sb_q[$];

  logic [127:0] pt_v, key_v;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] recomb2(input logic [255:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = s[2*i] ^ s[2*i+1];
    return r;
  endfunction

  function automatic logic [127:0] recomb3(input logic [383:0] s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = s[3*i] ^ s[3*i+1] ^ s[3*i+2];
    return r;
  endfunction

  task automatic model_clear();
    m_offer = 1'b0;
    m_cnt   = 0;
    m_pt2 = '0; m_key2 = '0; m_pt3 = '0; m_key3 = '0;
    m_pt_u = '0; m_key_u = '0;
    sb_q.delete();
  endtask

  task automatic step(input logic iv, input logic [31:0] data, input logic rv,
                      input logic fl, input logic cr, input logic [31:0] r2);
    logic         exp_rdy;
    logic         acc;
    logic [255:0] blk;
    @(negedge clk);
    in_valid   = iv;
    in_data    = data;
    rnd_valid  = rv;
    flush      = fl;
    core_ready = cr;
    rnd2       = r2;
    rnd3       = {$urandom(), $urandom()};
    #1;
    exp_rdy = !m_offer && rv && !fl;
    acc     = iv && exp_rdy;
    if (rnd_ready2) dut_pulses++;
    check("in_ready_d2", 384'(in_ready2), 384'(exp_rdy));
    check("in_ready_d3", 384'(in_ready3), 384'(exp_rdy));
    check("rnd_ready_d2", 384'(rnd_ready2), 384'(acc));
    check("rnd_ready_d3", 384'(rnd_ready3), 384'(acc));
    check("valid_out_d2", 384'(valid_out2), 384'(m_offer));
    check("valid_out_d3", 384'(valid_out3), 384'(m_offer));
    check("sh_pt_d2", 384'(sh_pt2), 384'(m_pt2));
    check("sh_key_d2", 384'(sh_key2), 384'(m_key2));
    check("sh_pt_d3", sh_pt3, m_pt3);
    check("sh_key_d3", sh_key3, m_key3);
    if (m_offer) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL scoreboard_empty observed=0 entries expected=1");
      end else begin
        blk = sb_q[0];
        check("recomb_pt_d2", 384'(recomb2(sh_pt2)), 384'(blk[127:0]));
        check("recomb_key_d2", 384'(recomb2(sh_key2)), 384'(blk[255:128]));
        check("recomb_pt_d3", 384'(recomb3(sh_pt3)), 384'(blk[127:0]));
        check("recomb_key_d3", 384'(recomb3(sh_key3)), 384'(blk[255:128]));
        if (cr) begin
          void'(sb_q.pop_front());
          m_offer = 1'b0;
        end
      end
    end else if (fl) begin
      m_cnt = 0;
    end else if (acc) begin
      for (int b = 0; b < 32; b++) begin
        int i;
        i = 32*(m_cnt % 4) + b;
        if (m_cnt < 4) begin
          m_pt2[2*i]   = data[b] ^ r2[b];
          m_pt2[2*i+1] = r2[b];
          m_pt3[3*i]   = data[b] ^ rnd3[b] ^ rnd3[32+b];
          m_pt3[3*i+1] = rnd3[b];
          m_pt3[3*i+2] = rnd3[32+b];
        end else begin
          m_key2[2*i]   = data[b] ^ r2[b];
          m_key2[2*i+1] = r2[b];
          m_key3[3*i]   = data[b] ^ rnd3[b] ^ rnd3[32+b];
          m_key3[3*i+1] = rnd3[b];
          m_key3[3*i+2] = rnd3[32+b];
        end
      end
      if (m_cnt < 4) m_pt_u[32*m_cnt +: 32] = data;
      else           m_key_u[32*(m_cnt-4) +: 32] = data;
      m_cnt++;
      if (m_cnt == 8) begin
        sb_q.push_back({m_key_u, m_pt_u});
        m_cnt   = 0;
        m_offer = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid   = 1'b1;
    rnd_valid  = 1'b1;
    flush      = 1'b0;
    core_ready = 1'b0;
    nrst       = 1'b0;
    #1;
    check("rst_in_ready", 384'(in_ready2), 384'(0));
    check("rst_rnd_ready", 384'(rnd_ready3), 384'(0));
    check("rst_valid_out_d2", 384'(valid_out2), 384'(0));
    check("rst_valid_out_d3", 384'(valid_out3), 384'(0));
    check("rst_sh_pt_d2", 384'(sh_pt2), 384'(0));
    check("rst_sh_key_d2", 384'(sh_key2), 384'(0));
    check("rst_sh_pt_d3", sh_pt3, 384'(0));
    check("rst_sh_key_d3", sh_key3, 384'(0));
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    nrst     = 1'b1;
  endtask

  initial begin
    nrst = 1'b0; in_valid = 1'b0; in_data = '0; rnd_valid = 1'b0;
    flush = 1'b0; core_ready = 1'b0; rnd2 = '0; rnd3 = '0;
    model_clear();
    do_reset();

    // All-zero block under a fixed mask pattern
    for (int k = 0; k < 8; k++) step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);

    // Known plaintext/key with random masks, then a stalled offer with flush ignored
    pt_v  = 128'h340737e0a29831318d305a88a8f64332;
    key_v = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    dut_pulses = 0;
    for (int k = 0; k < 8; k++)
      step(1'b1, (k < 4) ? pt_v[32*k +: 32] : key_v[32*(k-4) +: 32], 1'b1, 1'b0, 1'b0, $urandom());
    check("rnd_pulses", 384'(dut_pulses), 384'(8));
    for (int s = 0; s < 5; s++) step(1'b1, $urandom(), 1'b1, (s == 2), 1'b0, $urandom());
    step(1'b1, $urandom(), 1'b1, 1'b0, 1'b1, $urandom());

    // Back-to-back block with randomness available only every other cycle
    dut_pulses = 0;
    for (int s = 0; s < 16; s++) step(1'b1, $urandom(), (s % 2 == 0), 1'b0, 1'b0, $urandom());
    check("toggle_pulses", 384'(dut_pulses), 384'(8));
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, $urandom());

    // Flush after three words, then a full fresh block
    for (int k = 0; k < 3; k++) step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, $urandom());
    step(1'b1, $urandom(), 1'b1, 1'b1, 1'b0, $urandom());
    for (int k = 0; k < 8; k++) step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, $urandom());
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, $urandom());

    // Reset after five words, then reload from word 0
    for (int k = 0; k < 5; k++) step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, $urandom());
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, $urandom(), 1'b1, 1'b0, 1'b0, $urandom());
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, $urandom());
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, $urandom());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mskaes_input_sharer.md
MSKAES_INPUT_SHARER -- requirements
Module: mskaes_input_sharer

Interface
REQ-001 Parameter d, default 2, number of shares per bit; d SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 nrst  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  unmasked 32-bit word available on in_data.
REQ-005 in_data  input  32  unmasked word: words 0-3 plaintext, words 4-7 key, least-significant word first.
REQ-006 in_ready  output  1  word accepted on in_valid && in_ready.
REQ-007 rnd_valid  input  1  fresh randomness present on rnd (driven by PRNG out_valid).
REQ-008 rnd  input  32*(d-1)  fresh random bits for one word.
REQ-009 rnd_ready  output  1  randomness consumed this cycle.
REQ-010 sh_plaintext  output  128*d  shared plaintext, bit-interleaved: share j of bit i at index d*i+j.
REQ-011 sh_key  output  128*d  shared key, same encoding.
REQ-012 valid_out  output  1  shared block ready for core (connects to core valid_in).
REQ-013 core_ready  input  1  core accepts block on valid_out && core_ready.
REQ-014 flush  input  1  synchronous abort of partially loaded block.

Function
REQ-015 FSM states SHALL be LOAD, OFFER; word counter cnt SHALL be 3 bits.
REQ-016 in_ready SHALL equal (state==LOAD) && rnd_valid && !flush, combinationally.
REQ-017 rnd_ready SHALL equal in_valid && in_ready; exactly one rnd vector consumed per accepted word, none otherwise.
REQ-018 On accept, for bit b of word k (global bit i=32*(k mod 4)+b): shares j=1..d-1 SHALL take rnd[(j-1)*32+b]; share 0 SHALL take in_data[b] XOR all those random bits.
REQ-019 Words k=0..3 SHALL write sh_plaintext, k=4..7 SHALL write sh_key; other share bits unchanged.
REQ-020 Each accept SHALL increment cnt; accept with cnt==7 SHALL set cnt to 0 and move to OFFER on the next edge.
REQ-021 In OFFER, valid_out SHALL be 1 (registered) and sh_plaintext/sh_key SHALL be held stable; in LOAD valid_out SHALL be 0.
REQ-022 In OFFER, valid_out && core_ready SHALL return FSM to LOAD next edge; valid_out SHALL be high for exactly the handshake cycle plus any preceding stall cycles.
REQ-023 No words SHALL be accepted in OFFER (in_ready=0), regardless of in_valid/rnd_valid.
REQ-024 in_valid without rnd_valid SHALL stall (no accept, no cnt change, rnd_ready=0).
REQ-025 flush in LOAD SHALL clear cnt to 0 next edge and block any accept that cycle; share registers need not clear.
REQ-026 flush in OFFER SHALL be ignored; block is still offered until handshake.
REQ-027 Latency: from 8th accept to valid_out high SHALL be 1 cycle; back-to-back blocks SHALL be possible with first word of next block accepted the cycle after the handshake.
REQ-028 Recombined value (XOR of d shares) of every bit SHALL equal the accepted unmasked bit; no unmasked word SHALL be stored in any register.

Reset
REQ-029 nrst low SHALL immediately force state=LOAD, cnt=0, valid_out=0, sh_plaintext=0, sh_key=0.
REQ-030 in_ready and rnd_ready SHALL be 0 while nrst is low.
REQ-031 Reset mid-load or mid-offer SHALL discard the partial/offered block; loading restarts from word 0 after release.

Verification
REQ-032 d=2, rnd_valid=1, rnd=0xA5A5A5A5 fixed, 8 words all 0 -> valid_out high 1 cycle after 8th accept; every share pair equals (share0,share1) per rnd bit, XOR-recombined plaintext and key = 0.
REQ-033 d=2, plaintext 0x340737e0a29831318d305a88a8f64332, key 0x3c4fcf098815f7aba6d2ae2816157e2b, random rnd -> recombined outputs equal these values exactly; 8 rnd_ready pulses counted.
REQ-034 rnd_valid toggled 0/1 every cycle with in_valid=1 -> accepts only on rnd_valid=1 cycles; load completes in 16 cycles; no randomness reused.
REQ-035 core_ready=0 for 5 cycles in OFFER, in_valid=1 -> valid_out held 5+ cycles, shares stable, in_ready=0; handshake on core_ready=1, then LOAD.
REQ-036 flush after 3 words, then 8 fresh words -> block contains only the 8 post-flush words; nrst pulsed after 5 words -> all outputs 0, reload from word 0 succeeds.
REQ-037 d=3 run of REQ-033 -> recombination of 3 shares matches; share 1 and 2 bits equal rnd words.
